// File: rtl/sync_ctl_multi.sv
// sync_ctl_multi
//
// Frame synchronizer controller for the OFDM receive path. It watches the
// coarse double-correlation metric for a plateau above threshold. Once a
// plateau is found it freezes the capture BRAM after a fill period. It then
// replays the captured window through a programmable downsampler. After the
// fine-correlation lock it streams up to n_sym FFT frames, dropping
// cyclic-prefix samples between consecutive frames.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   addra / wea          BRAM write address (in) and write enable (out)
//   addrb / reb          BRAM read address (in) and read-counter enable (out)
//   addrb_load_en/_load  one-cycle load strobe and start address for the read counter
//   dc_metric_i          coarse metric, unsigned
//   cfg_*                run-time configuration (downsamp/cp_len/n_sym latched at capture)
//   abort                synchronous return to IDLE from any state
//   fine_trigger         fine-correlation lock pulse
//   valid_downsamp       decimated sample strobe during replay
//   valid_final          FFT input sample valid
//   last_final           last sample of an FFT frame
//   busy                 controller is not idle
//   err_no_fine          window ended without a fine lock (one-cycle pulse)
//   err_short            window ended before all frames were completed (one-cycle pulse)

module sync_ctl_multi #(
  parameter int ADDR_W   = 13,
  parameter int METRIC_W = 32,
  parameter int FFT_N    = 64,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addra,
  output logic                wea,
  input  logic [ADDR_W-1:0]   addrb,
  output logic                reb,
  output logic                addrb_load_en,
  output logic [ADDR_W-1:0]   addrb_load,
  input  logic [METRIC_W-1:0] dc_metric_i,
  input  logic [METRIC_W-1:0] cfg_dc_threshold,
  input  logic [CNT_W-1:0]    cfg_plateau_len,
  input  logic [CNT_W-1:0]    cfg_wait_len,
  input  logic [ADDR_W-1:0]   cfg_back_off,
  input  logic [ADDR_W-1:0]   cfg_seek_len,
  input  logic [7:0]          cfg_downsamp,
  input  logic [5:0]          cfg_cp_len,
  input  logic [7:0]          cfg_n_sym,
  input  logic                abort,
  input  logic                fine_trigger,
  output logic                valid_downsamp,
  output logic                valid_final,
  output logic                last_final,
  output logic                busy,
  output logic                err_no_fine,
  output logic                err_short
);

  localparam int SMP_W = $clog2(FFT_N);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(FFT_N - 1);

  typedef enum logic [2:0] {
    IDLE,
    PLATEAU,
    CAPTURE,
    FILL,
    LOAD,
    READ
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    platCnt_q, platCnt_d;
  logic [CNT_W-1:0]    fillCnt_q, fillCnt_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [7:0]          ds_q, ds_d;
  logic [5:0]          cp_q, cp_d;
  logic [7:0]          nSym_q, nSym_d;
  logic [7:0]          dsCnt_q, dsCnt_d;
  logic [SMP_W-1:0]    smpCnt_q, smpCnt_d;
  logic [5:0]          skipCnt_q, skipCnt_d;
  logic [7:0]          symCnt_q, symCnt_d;
  logic                armed_q, armed_d;
  logic                everArmed_q, everArmed_d;
  logic                done_q, done_d;

  logic                dsStrobe;
  logic                metricHigh;
  logic [8:0]          framesDone;

  assign metricHigh = (dc_metric_i >= cfg_dc_threshold);

  // State and counter registers. Reset returns everything to the idle,
  // write-enabled condition with all counters and flags cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      platCnt_q   <= '0;
      fillCnt_q   <= '0;
      start_q     <= '0;
      end_q       <= '0;
      ds_q        <= 8'd1;
      cp_q        <= '0;
      nSym_q      <= 8'd1;
      dsCnt_q     <= '0;
      smpCnt_q    <= '0;
      skipCnt_q   <= '0;
      symCnt_q    <= '0;
      armed_q     <= 1'b0;
      everArmed_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      platCnt_q   <= platCnt_d;
      fillCnt_q   <= fillCnt_d;
      start_q     <= start_d;
      end_q       <= end_d;
      ds_q        <= ds_d;
      cp_q        <= cp_d;
      nSym_q      <= nSym_d;
      dsCnt_q     <= dsCnt_d;
      smpCnt_q    <= smpCnt_d;
      skipCnt_q   <= skipCnt_d;
      symCnt_q    <= symCnt_d;
      armed_q     <= armed_d;
      everArmed_q <= everArmed_d;
      done_q      <= done_d;
    end
  end

  // Next-state and output decode. The outputs follow the registered state.
  // The exception is the exit-cycle error pulses, which depend on the live
  // read address. Abort overrides whatever the state logic decided and
  // suppresses those error pulses.
  always_comb begin
    state_d        = state_q;
    platCnt_d      = platCnt_q;
    fillCnt_d      = fillCnt_q;
    start_d        = start_q;
    end_d          = end_q;
    ds_d           = ds_q;
    cp_d           = cp_q;
    nSym_d         = nSym_q;
    dsCnt_d        = dsCnt_q;
    smpCnt_d       = smpCnt_q;
    skipCnt_d      = skipCnt_q;
    symCnt_d       = symCnt_q;
    armed_d        = armed_q;
    everArmed_d    = everArmed_q;
    done_d         = done_q;

    wea            = 1'b1;
    reb            = 1'b0;
    addrb_load_en  = 1'b0;
    addrb_load     = '0;
    valid_downsamp = 1'b0;
    valid_final    = 1'b0;
    last_final     = 1'b0;
    err_no_fine    = 1'b0;
    err_short      = 1'b0;
    busy           = (state_q != IDLE);
    dsStrobe       = 1'b0;
    framesDone     = '0;

    case (state_q)
      IDLE: begin
        platCnt_d   = '0;
        dsCnt_d     = '0;
        smpCnt_d    = '0;
        skipCnt_d   = '0;
        symCnt_d    = '0;
        armed_d     = 1'b0;
        everArmed_d = 1'b0;
        done_d      = 1'b0;
        if (metricHigh) begin
          state_d = PLATEAU;
        end
      end

      PLATEAU: begin
        if (!metricHigh) begin
          state_d = IDLE;
        end else if (platCnt_q == cfg_plateau_len) begin
          state_d = CAPTURE;
        end else begin
          platCnt_d = platCnt_q + 1'b1;
        end
      end

      CAPTURE: begin
        // Window bounds wrap modulo the BRAM depth.
        start_d   = addra - cfg_back_off;
        end_d     = addra - cfg_back_off + cfg_seek_len;
        ds_d      = (cfg_downsamp == 8'd0) ? 8'd1 : cfg_downsamp;
        cp_d      = cfg_cp_len;
        nSym_d    = (cfg_n_sym == 8'd0) ? 8'd1 : cfg_n_sym;
        fillCnt_d = '0;
        state_d   = FILL;
      end

      FILL: begin
        if (fillCnt_q == cfg_wait_len) begin
          state_d = LOAD;
        end else begin
          fillCnt_d = fillCnt_q + 1'b1;
        end
      end

      LOAD: begin
        wea           = 1'b0;
        addrb_load_en = 1'b1;
        addrb_load    = start_q;
        state_d       = READ;
      end

      READ: begin
        wea            = 1'b0;
        reb            = 1'b1;
        dsStrobe       = (dsCnt_q == ds_q - 8'd1);
        valid_downsamp = dsStrobe;
        dsCnt_d        = dsStrobe ? 8'd0 : dsCnt_q + 8'd1;

        // A trigger arms the output from the following cycle. The strobe
        // in the trigger cycle itself is therefore never emitted.
        if (armed_q && dsStrobe) begin
          if (skipCnt_q != 6'd0) begin
            skipCnt_d = skipCnt_q - 6'd1;
          end else begin
            valid_final = 1'b1;
            smpCnt_d    = smpCnt_q + 1'b1;
            if (smpCnt_q == SMP_LAST) begin
              last_final = 1'b1;
              smpCnt_d   = '0;
              symCnt_d   = symCnt_q + 8'd1;
              skipCnt_d  = cp_q;
              if ({1'b0, symCnt_q} + 9'd1 == {1'b0, nSym_q}) begin
                armed_d = 1'b0;
                done_d  = 1'b1;
              end
            end
          end
        end else if (fine_trigger && !armed_q && !done_q) begin
          armed_d     = 1'b1;
          everArmed_d = 1'b1;
        end

        // A frame finishing in the exit cycle still counts as completed.
        framesDone = {1'b0, symCnt_q} + {8'd0, last_final};
        if (addrb == end_q) begin
          state_d = IDLE;
          if (!everArmed_q) begin
            err_no_fine = !rst;
          end else if (framesDone < {1'b0, nSym_q}) begin
            err_short = !rst;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d     = IDLE;
      err_no_fine = 1'b0;
      err_short   = 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_ctl_multi.sv
// tb_sync_ctl_multi
//
// Bench for sync_ctl_multi. The bench drives each window replay with
// randomized and directed parameters. During replay it compares every cycle
// against expected strobes. Those expectations come from the frame/skip
// arithmetic: armed strobes are grouped into periods of FFT_N emitted
// samples plus cp_len skipped ones. The tb models the write and read
// address counters.

module tb_sync_ctl_multi;

  logic        clk;
  logic        rst;
  logic [12:0] addra;
  logic        wea;
  logic [12:0] addrb;
  logic        reb;
  logic        addrb_load_en;
  logic [12:0] addrb_load;
  logic [31:0] dc_metric_i;
  logic [31:0] cfg_dc_threshold;
  logic [15:0] cfg_plateau_len;
  logic [15:0] cfg_wait_len;
  logic [12:0] cfg_back_off;
  logic [12:0] cfg_seek_len;
  logic [7:0]  cfg_downsamp;
  logic [5:0]  cfg_cp_len;
  logic [7:0]  cfg_n_sym;
  logic        abort;
  logic        fine_trigger;
  logic        valid_downsamp;
  logic        valid_final;
  logic        last_final;
  logic        busy;
  logic        err_no_fine;
  logic        err_short;

  int errors = 0;
  int checks = 0;

  logic [31:0] metricHiMin, metricHiMax, metricLo;

  logic        sWea, sReb, sLd, sBusy, sVds, sVf, sLf, sEnf, sEs;
  logic [12:0] sLdAddr;

  sync_ctl_multi dut (
    .clk              (clk),
    .rst              (rst),
    .addra            (addra),
    .wea              (wea),
    .addrb            (addrb),
    .reb              (reb),
    .addrb_load_en    (addrb_load_en),
    .addrb_load       (addrb_load),
    .dc_metric_i      (dc_metric_i),
    .cfg_dc_threshold (cfg_dc_threshold),
    .cfg_plateau_len  (cfg_plateau_len),
    .cfg_wait_len     (cfg_wait_len),
    .cfg_back_off     (cfg_back_off),
    .cfg_seek_len     (cfg_seek_len),
    .cfg_downsamp     (cfg_downsamp),
    .cfg_cp_len       (cfg_cp_len),
    .cfg_n_sym        (cfg_n_sym),
    .abort            (abort),
    .fine_trigger     (fine_trigger),
    .valid_downsamp   (valid_downsamp),
    .valid_final      (valid_final),
    .last_final       (last_final),
    .busy             (busy),
    .err_no_fine      (err_no_fine),
    .err_short        (err_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle. Outputs are sampled on the falling edge. The modeled
  // write and read address counters advance just after the rising edge.
  task automatic tick();
    @(negedge clk);
    sWea = wea; sReb = reb; sLd = addrb_load_en; sBusy = busy;
    sVds = valid_downsamp; sVf = valid_final; sLf = last_final;
    sEnf = err_no_fine; sEs = err_short; sLdAddr = addrb_load;
    @(posedge clk);
    #1;
    if (sLd) addrb = sLdAddr;
    else if (sReb) addrb = addrb + 13'd1;
    addra = addra + 13'd1;
  endtask

  // Vector order: wea reb ld busy vds vf lf enf es
  task automatic test_reset();
    logic [8:0] obs;
    rst = 1'b1;
    dc_metric_i = 32'd0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      obs = {sWea, sReb, sLd, sBusy, sVds, sVf, sLf, sEnf, sEs};
      checks++;
      if (obs !== 9'b1_0000_0000) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle=%0d got=%b want=%b", i, obs, 9'b1_0000_0000);
      end
      checks++;
      if (sLdAddr !== 13'd0) begin
        errors++;
        $display("[TB] FAIL reset_load_addr got=%0d want=0", sLdAddr);
      end
    end
  endtask

  // Full detection, capture and replay of one window. The trigger lands at
  // READ cycle 'trig', or never when trig < 0. abortAt/rstAt are READ cycle
  // indices, or -1 for none.
  task automatic run_window(input string name, input int plat, input int waitL,
                            input int ds, input int cp, input int nsym, input int seek,
                            input int backOff, input int startWant, input int trig,
                            input int abortAt, input int rstAt, input bit extraTrig);
    int dsEff, nsEff, addraCap, bo, expStart, loadC, exitK, j, f, p, completed;
    bit stopped, everArmed;
    int expVds[], expVf[], expLf[];
    logic [8:0] obs, expV;

    dsEff = (ds == 0) ? 1 : ds;
    nsEff = (nsym == 0) ? 1 : nsym;
    cfg_plateau_len = 16'(plat);
    cfg_wait_len    = 16'(waitL);
    cfg_downsamp    = 8'(ds);
    cfg_cp_len      = 6'(cp);
    cfg_n_sym       = 8'(nsym);
    cfg_seek_len    = 13'(seek);
    addraCap = (int'(addra) + plat + 2) & 8191;
    bo = (startWant >= 0) ? ((addraCap - startWant) & 8191) : backOff;
    cfg_back_off = 13'(bo);
    expStart = (addraCap - bo) & 8191;
    loadC = plat + waitL + 4;

    for (int c = 0; c <= loadC; c++) begin
      dc_metric_i = (c <= plat + 1) ? $urandom_range(metricHiMax, metricHiMin) : metricLo;
      tick();
      obs  = {sWea, sReb, sLd, sBusy, 5'b0};
      expV = {(c != loadC), 1'b0, (c == loadC), (c != 0), 5'b0};
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("[TB] FAIL %s pre c=%0d got=%b want=%b", name, c, obs, expV);
      end
      if (c == loadC) begin
        checks++;
        if (sLdAddr !== 13'(expStart)) begin
          errors++;
          $display("[TB] FAIL %s load_addr got=%0d want=%0d", name, sLdAddr, expStart);
        end
      end
      // Once captured, the latched settings must not follow the inputs.
      if (c == plat + 2) begin
        cfg_downsamp = 8'($urandom);
        cfg_cp_len   = 6'($urandom);
        cfg_n_sym    = 8'($urandom);
        cfg_back_off = 13'($urandom);
        cfg_seek_len = 13'($urandom);
      end
    end

    // Expected strobes per READ cycle, derived from frame/skip arithmetic.
    expVds = new[seek + 1];
    expVf  = new[seek + 1];
    expLf  = new[seek + 1];
    j = 0;
    completed = 0;
    for (int k = 0; k <= seek; k++) begin
      expVds[k] = ((k % dsEff) == dsEff - 1) ? 1 : 0;
      expVf[k] = 0;
      expLf[k] = 0;
      if (expVds[k] == 1 && trig >= 0 && k > trig) begin
        f = j / (64 + cp);
        p = j % (64 + cp);
        if (f < nsEff && p < 64) begin
          expVf[k] = 1;
          expLf[k] = (p == 63) ? 1 : 0;
          completed += expLf[k];
        end
        j++;
      end
    end
    everArmed = (trig >= 0 && trig < seek);
    exitK = seek;
    stopped = 1'b0;
    if (abortAt >= 0 && abortAt <= exitK) begin exitK = abortAt; stopped = 1'b1; end
    if (rstAt >= 0 && rstAt <= exitK) begin exitK = rstAt; stopped = 1'b1; end

    for (int k = 0; k <= exitK; k++) begin
      fine_trigger = (k == trig) || (extraTrig && trig >= 0 && k > trig && ($urandom % 7 == 0));
      abort = (k == abortAt);
      rst   = (k == rstAt);
      tick();
      obs  = {sWea, sReb, sLd, sBusy, sVds, sVf, sLf, sEnf, sEs};
      expV = {4'b0101, expVds[k][0], expVf[k][0], expLf[k][0],
              (!stopped && k == seek && !everArmed),
              (!stopped && k == seek && everArmed && completed < nsEff)};
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("[TB] FAIL %s read k=%0d got=%b want=%b", name, k, obs, expV);
      end
    end
    fine_trigger = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    tick();
    obs = {sWea, sReb, sLd, sBusy, sVds, sVf, sLf, sEnf, sEs};
    checks++;
    if (obs !== 9'b1_0000_0000 || sLdAddr !== 13'd0) begin
      errors++;
      $display("[TB] FAIL %s after_exit got=%b addr=%0d want=%b addr=0", name, obs, sLdAddr, 9'b1_0000_0000);
    end
  endtask

  // Plateau one cycle short: no capture, busy falls after the drop, wea high.
  task automatic test_detect_boundary();
    cfg_dc_threshold = 32'd900000;
    metricHiMin = 32'd900000;
    metricHiMax = 32'd900000;
    metricLo = 32'd0;
    cfg_plateau_len = 16'd1000;
    cfg_wait_len = 16'd3;
    for (int c = 0; c < 1010; c++) begin
      dc_metric_i = (c < 1001) ? 32'd900000 : 32'd0;
      tick();
      checks++;
      if (sWea !== 1'b1 || sLd !== 1'b0) begin
        errors++;
        $display("[TB] FAIL short_plateau c=%0d wea=%b ld=%b want wea=1 ld=0", c, sWea, sLd);
      end
      if (c == 1001 || c == 1002) begin
        checks++;
        if (sBusy !== (c == 1001)) begin
          errors++;
          $display("[TB] FAIL short_plateau_busy c=%0d got=%b want=%b", c, sBusy, (c == 1001));
        end
      end
    end
  endtask

  task automatic test_downsamp25();
    run_window("ds25_plateau1002", 1000, 3, 25, 0, 1, 1800, 1710, -1, 100, -1, -1, 1'b0);
  endtask

  task automatic test_multi_sym();
    cfg_dc_threshold = 32'd5000;
    metricHiMin = 32'd5000;
    metricHiMax = 32'd9000;
    metricLo = 32'd4999;
    run_window("multi_sym", 2, 1, 2, 16, 3, 600, 100, -1, 10, -1, -1, 1'b1);
  endtask

  task automatic test_errors();
    run_window("no_fine", 3, 2, 1, 5, 1, 3650, 200, -1, -1, -1, -1, 1'b0);
    run_window("short", 1, 0, 1, 4, 3, 150, 50, -1, 5, -1, -1, 1'b1);
    run_window("zero_len", 0, 0, 1, 0, 1, 0, 7, -1, -1, -1, -1, 1'b0);
  endtask

  task automatic test_wrap_abort_rst();
    run_window("wrap", 2, 2, 0, 0, 1, 20, 0, 8185, 2, -1, -1, 1'b0);
    run_window("abort_read", 1, 1, 3, 2, 2, 300, 30, -1, 4, 30, -1, 1'b0);
    run_window("abort_at_end", 1, 1, 1, 0, 1, 40, 30, -1, -1, 40, -1, 1'b0);
    run_window("rst_at_end", 1, 1, 1, 0, 1, 40, 30, -1, -1, -1, 40, 1'b0);
    run_window("rst_read", 1, 1, 2, 0, 1, 200, 30, -1, 3, -1, 90, 1'b0);
  endtask

  // Abort during FILL returns to IDLE with no load ever issued.
  task automatic test_abort_fill();
    cfg_plateau_len = 16'd1;
    cfg_wait_len = 16'd10;
    for (int c = 0; c < 20; c++) begin
      dc_metric_i = (c < 3) ? metricHiMin : metricLo;
      abort = (c == 6);
      tick();
      checks++;
      if (sLd !== 1'b0 || sWea !== 1'b1 || sBusy !== (c >= 1 && c <= 6)) begin
        errors++;
        $display("[TB] FAIL abort_fill c=%0d ld=%b wea=%b busy=%b want ld=0 wea=1 busy=%b",
                 c, sLd, sWea, sBusy, (c >= 1 && c <= 6));
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_random();
    int seek, trig, ab;
    for (int r = 0; r < 10; r++) begin
      cfg_dc_threshold = $urandom_range(2000000, 1000);
      metricHiMin = cfg_dc_threshold;
      metricHiMax = cfg_dc_threshold + 1000;
      metricLo = $urandom_range(cfg_dc_threshold - 1, 0);
      seek = $urandom_range(700, 0);
      trig = ($urandom % 5 == 0) ? -1 : int'($urandom_range(seek, 0));
      ab = ($urandom % 4 == 0) ? int'($urandom_range(seek, 0)) : -1;
      run_window($sformatf("random%0d", r), $urandom_range(5, 0), $urandom_range(5, 0),
                 $urandom_range(4, 0), $urandom_range(20, 0), $urandom_range(3, 0), seek,
                 $urandom_range(8191, 0), -1, trig, ab, -1, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    addra = 13'd100;
    addrb = 13'd0;
    dc_metric_i = 32'd0;
    cfg_dc_threshold = 32'd900000;
    cfg_plateau_len = 16'd0;
    cfg_wait_len = 16'd0;
    cfg_back_off = 13'd0;
    cfg_seek_len = 13'd0;
    cfg_downsamp = 8'd1;
    cfg_cp_len = 6'd0;
    cfg_n_sym = 8'd1;
    abort = 1'b0;
    fine_trigger = 1'b0;
    metricHiMin = 32'd900000;
    metricHiMax = 32'd900000;
    metricLo = 32'd0;

    test_reset();
    test_detect_boundary();
    test_downsamp25();
    test_multi_sym();
    test_errors();
    test_wrap_abort_rst();
    test_abort_fill();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
